video_timing_gen: RTL

//   Parametrised raster timing generator. Successor to the fixed 640x480 VGA sync block.
//   - Counter width, sync polarity and the default mode are set by parameters.
//   - The block has a pixel clock enable.
//   - The timing mode can be reloaded at run time through a valid/ready port. A new mode takes effect only on a frame boundary.
//   - It drives HS/VS, data-enable, pixel coordinates and frame/line strobes to the pixel pipeline and the DAC/encoder.

---
 rtl/video_timing_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with run-time mode reload
module video_timing_gen #(
  parameter int CNT_W    = 11,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic [4*CNT_W-1:0] i_cfg_h,
  input  logic [4*CNT_W-1:0] i_cfg_v,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  output logic               o_cfg_err,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic [CNT_W-1:0]   o_px,
  output logic [CNT_W-1:0]   o_py,
  output logic               o_sol,
  output logic               o_sof
);

  localparam logic [CNT_W-1:0] DEF_H_SYNC = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] DEF_H_BP   = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] DEF_H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] DEF_H_FP   = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] DEF_V_SYNC = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DEF_V_BP   = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0] DEF_V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] DEF_V_FP   = CNT_W'(V_FP);

  // Largest total a counter of CNT_W bits can reach (counts 0..TOT-1).
  localparam logic [CNT_W+1:0] TOT_MAX = {2'b00, {CNT_W{1'b1}}};

  // Active mode registers: the only source for all timing arithmetic.
  logic [CNT_W-1:0] h_sync, h_bp, h_act, h_fp;
  logic [CNT_W-1:0] v_sync, v_bp, v_act, v_fp;

  // Accepted mode waiting for the next frame boundary.
  logic [4*CNT_W-1:0] pend_h, pend_v;
  logic               pend_valid;
  logic               cfg_ready;
  logic               cfg_err;

  logic [CNT_W-1:0] hcnt, vcnt;

  // Segment boundaries derived from the active mode.
  logic [CNT_W-1:0] h_act_start, h_act_end, h_last;
  logic [CNT_W-1:0] v_act_start, v_act_end, v_last;
  logic             h_at_end, v_at_end, frame_end;
  logic             hact, vact;

  // Fields of the offered mode, and its legality.
  logic [CNT_W-1:0] in_h_sync, in_h_bp, in_h_act, in_h_fp;
  logic [CNT_W-1:0] in_v_sync, in_v_bp, in_v_act, in_v_fp;
  logic [CNT_W+1:0] in_h_tot, in_v_tot;
  logic             in_ok;
  logic             xfer;

  assign h_act_start = h_sync + h_bp;
  assign h_act_end   = h_act_start + h_act;
  assign h_last      = h_act_end + h_fp - CNT_W'(1);
  assign v_act_start = v_sync + v_bp;
  assign v_act_end   = v_act_start + v_act;
  assign v_last      = v_act_end + v_fp - CNT_W'(1);

  assign h_at_end  = (hcnt == h_last);
  assign v_at_end  = (vcnt == v_last);
  assign frame_end = i_ce && h_at_end && v_at_end;

  assign hact = (hcnt >= h_act_start) && (hcnt < h_act_end);
  assign vact = (vcnt >= v_act_start) && (vcnt < v_act_end);

  assign in_h_sync = i_cfg_h[4*CNT_W-1 -: CNT_W];
  assign in_h_bp   = i_cfg_h[3*CNT_W-1 -: CNT_W];
  assign in_h_act  = i_cfg_h[2*CNT_W-1 -: CNT_W];
  assign in_h_fp   = i_cfg_h[CNT_W-1:0];
  assign in_v_sync = i_cfg_v[4*CNT_W-1 -: CNT_W];
  assign in_v_bp   = i_cfg_v[3*CNT_W-1 -: CNT_W];
  assign in_v_act  = i_cfg_v[2*CNT_W-1 -: CNT_W];
  assign in_v_fp   = i_cfg_v[CNT_W-1:0];

  // Two guard bits so the sum of four CNT_W fields cannot wrap.
  assign in_h_tot = (CNT_W+2)'(in_h_sync) + (CNT_W+2)'(in_h_bp)
                  + (CNT_W+2)'(in_h_act)  + (CNT_W+2)'(in_h_fp);
  assign in_v_tot = (CNT_W+2)'(in_v_sync) + (CNT_W+2)'(in_v_bp)
                  + (CNT_W+2)'(in_v_act)  + (CNT_W+2)'(in_v_fp);

  assign in_ok = (in_h_sync != '0) && (in_h_act != '0)
              && (in_v_sync != '0) && (in_v_act != '0)
              && (in_h_tot <= TOT_MAX) && (in_v_tot <= TOT_MAX);

  assign xfer = i_cfg_valid && cfg_ready;

  assign o_cfg_ready = cfg_ready;
  assign o_cfg_err   = cfg_err;

  // Mode handshake: store a legal offer as pending, load it at the end of the frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      h_sync     <= DEF_H_SYNC;
      h_bp       <= DEF_H_BP;
      h_act      <= DEF_H_ACT;
      h_fp       <= DEF_H_FP;
      v_sync     <= DEF_V_SYNC;
      v_bp       <= DEF_V_BP;
      v_act      <= DEF_V_ACT;
      v_fp       <= DEF_V_FP;
      pend_h     <= '0;
      pend_v     <= '0;
      pend_valid <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= xfer && !in_ok;
      // Only a mode that was already pending is applied; an offer taken in the
      // same cycle waits for the next frame boundary.
      if (frame_end && pend_valid) begin
        h_sync     <= pend_h[4*CNT_W-1 -: CNT_W];
        h_bp       <= pend_h[3*CNT_W-1 -: CNT_W];
        h_act      <= pend_h[2*CNT_W-1 -: CNT_W];
        h_fp       <= pend_h[CNT_W-1:0];
        v_sync     <= pend_v[4*CNT_W-1 -: CNT_W];
        v_bp       <= pend_v[3*CNT_W-1 -: CNT_W];
        v_act      <= pend_v[2*CNT_W-1 -: CNT_W];
        v_fp       <= pend_v[CNT_W-1:0];
        pend_valid <= 1'b0;
        cfg_ready  <= 1'b1;
      end
      // A transfer needs cfg_ready, which is never set while a mode is pending,
      // so this cannot collide with the apply above.
      if (xfer && in_ok) begin
        pend_h     <= i_cfg_h;
        pend_v     <= i_cfg_v;
        pend_valid <= 1'b1;
        cfg_ready  <= 1'b0;
      end
    end
  end

  // Raster counters, advancing on pixel enables and wrapping at the mode totals.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (i_ce) begin
      if (h_at_end) begin
        hcnt <= '0;
        vcnt <= v_at_end ? '0 : vcnt + CNT_W'(1);
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  // Registered outputs, one pixel behind the counters; strobes last one clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_hs  <= ~HS_POL;
      o_vs  <= ~VS_POL;
      o_de  <= 1'b0;
      o_px  <= '0;
      o_py  <= '0;
      o_sol <= 1'b0;
      o_sof <= 1'b0;
    end else begin
      o_sol <= i_ce && (hcnt == '0);
      o_sof <= i_ce && (hcnt == '0) && (vcnt == '0);
      if (i_ce) begin
        o_hs <= (hcnt < h_sync) ? HS_POL : ~HS_POL;
        o_vs <= (vcnt < v_sync) ? VS_POL : ~VS_POL;
        o_de <= hact && vact;
        o_px <= hact ? hcnt - h_act_start : '0;
        o_py <= vact ? vcnt - v_act_start : '0;
      end
    end
  end

endmodule
